fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FB_SIZE, default 122400, number of framebuffer cells (408x300, 1 bit each).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, write-FIFO entries (power of two, >=2).
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  system clock (48 MHz); all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 wr_req  input  1  writer (RK video side) pushes {wr_addr, wr_data} this cycle.
REQ-007 wr_addr  input  18  write cell address.
REQ-008 wr_data  input  1  write pixel value.
REQ-009 wr_full  output  1  write FIFO full.
REQ-010 rd_req  input  1  reader (VGA side) requests cell rd_addr this cycle.
REQ-011 rd_addr  input  18  read cell address.
REQ-012 rd_data  output  1  read pixel result.
REQ-013 rd_valid  output  1  rd_data valid, one cycle per accepted read.
REQ-014 clr_start  input  1  pulse: begin clearing whole buffer to 0.
REQ-015 clr_busy  output  1  clear sweep in progress.
REQ-016 ovf  output  1  sticky: a write was dropped.
REQ-017 ovf_clr  input  1  clears ovf.
REQ-018 ram_addr  output  18  single-port RAM address, registered.
REQ-019 ram_data  output  1  RAM write data, registered.
REQ-020 ram_wren  output  1  RAM write enable, registered.
REQ-021 ram_q  input  1  RAM read data, valid one cycle after RAM samples ram_addr.

Function
REQ-022 One RAM slot per cycle; slot grant priority: read > clear write > FIFO write; idle otherwise.
REQ-023 Every rd_req SHALL be granted the cycle it is asserted; reads are never deferred or dropped.
REQ-024 Granted slot in cycle N drives ram_addr/ram_data/ram_wren from edge ending N; read slot drives ram_wren=0.
REQ-025 Read latency fixed: rd_req in cycle N -> rd_valid=1, rd_data=RAM[rd_addr] in cycle N+3; 3-stage valid shift register, rd_data registered from ram_q.
REQ-026 Idle slot: ram_wren=0, ram_addr holds previous value.
REQ-027 Write FIFO: FIFO_DEPTH entries of {addr,data}, in-order; count 0..FIFO_DEPTH; wr_full = (count==FIFO_DEPTH).
REQ-028 Push when wr_req and (not full or pop same cycle); simultaneous push+pop when full is accepted, count unchanged.
REQ-029 wr_req while full with no pop: entry dropped, ovf set next cycle; FIFO contents unchanged.
REQ-030 ovf_clr clears ovf; simultaneous drop and ovf_clr: ovf stays 1 (set wins).
REQ-031 FIFO pop only in a slot not taken by read or clear; empty FIFO never pops.
REQ-032 FSM states RUN, CLEAR; reset -> RUN.
REQ-033 RUN -> CLEAR on clr_start: clear counter <= 0, clr_busy=1 from next cycle.
REQ-034 CLEAR: each non-read slot writes 0 to address = clear counter, counter increments; after writing FB_SIZE-1, -> RUN, clr_busy=0 next cycle.
REQ-035 clr_start during CLEAR ignored (no restart).
REQ-036 FIFO accepts pushes during CLEAR (may fill and overflow); contents drain after CLEAR.
REQ-037 Address arithmetic 18-bit unsigned; counter never exceeds FB_SIZE-1.
REQ-038 Write-after-read same address: read granted first returns old value; no forwarding from FIFO.

Reset
REQ-039 With rst_n=0 at an edge: FIFO empty, wr_full=0, rd_valid pipeline cleared, rd_valid=0, rd_data=0, ovf=0, state RUN, clr_busy=0, ram_wren=0, ram_addr=0, ram_data=0.
REQ-040 Reset mid-CLEAR or with FIFO non-empty: sweep aborted, pending writes discarded, no RAM write issued in cycle after reset.

Verification
REQ-041 Push addr 5 data 1 with rd_req low -> ram_wren=1, ram_addr=5, ram_data=1 one cycle later; read 5 -> rd_valid, rd_data=1 three cycles after rd_req.
REQ-042 rd_req held high 10 cycles with 4 pushes -> 10 rd_valid pulses, no ram_wren during reads, wr_full=1, 5th push sets ovf; release rd_req -> 4 writes in order.
REQ-043 Full FIFO, push+pop same cycle -> accepted, count stays 4, ovf stays 0.
REQ-044 clr_start with FB_SIZE=16, no reads -> 16 writes of 0 to addresses 0..15, clr_busy high exactly 16 cycles; with rd_req every other cycle -> 32 cycles.
REQ-045 rst_n low at clear address 7 -> clr_busy=0, ram_wren=0 next cycle, FIFO empty.
REQ-046 Drop and ovf_clr same cycle -> ovf=1; ovf_clr alone next -> ovf=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Framebuffer RAM port arbiter.
//
// Shares one single-port framebuffer RAM (1 bit per cell) between three
// users, one slot per clock:
//   - the VGA reader, which always wins the slot it asks for,
//   - a whole-buffer clear sweep that writes 0 to every cell,
//   - a small in-order write FIFO fed by the video writer.
// Read data comes back a fixed three cycles after rd_req.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   wr_req/wr_addr/wr_data writer push into the write FIFO
//   wr_full               write FIFO holds FIFO_DEPTH entries
//   rd_req/rd_addr        read request, granted the same cycle
//   rd_data/rd_valid      read result, three cycles after rd_req
//   clr_start/clr_busy    start a clear sweep / sweep in progress
//   ovf/ovf_clr           sticky dropped-write flag and its clear
//   ram_addr/ram_data/ram_wren  registered RAM port
//   ram_q                 RAM read data, one cycle after address sample
module fb_arbiter #(
    parameter int FB_SIZE    = 122400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [17:0] wr_addr,
    input  logic        wr_data,
    output logic        wr_full,
    input  logic        rd_req,
    input  logic [17:0] rd_addr,
    output logic        rd_data,
    output logic        rd_valid,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic [17:0] ram_addr,
    output logic        ram_data,
    output logic        ram_wren,
    input  logic        ram_q
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [17:0]   CLR_LAST = 18'(FB_SIZE - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [17:0]   clr_cnt_q, clr_cnt_d;

    logic [17:0]   fifo_addr_q [FIFO_DEPTH];
    logic          fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;

    logic          ovf_q, ovf_d;
    logic [2:0]    rd_vld_q;
    logic          rd_data_q;

    logic [17:0]   ram_addr_q, ram_addr_d;
    logic          ram_data_q, ram_data_d;
    logic          ram_wren_q, ram_wren_d;

    logic          fifo_full;
    logic          slot_clear;
    logic          pop;
    logic          push;
    logic          drop;

    // Slot arbitration: read > clear > FIFO. A pop frees an entry in the
    // same cycle, so a push against a full FIFO is still accepted then.
    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        slot_clear = !rd_req && (state_q == ST_CLEAR);
        pop        = !rd_req && (state_q == ST_RUN) && (count_q != '0);
        push       = wr_req && (!fifo_full || pop);
        drop       = wr_req && fifo_full && !pop;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Drop wins over a simultaneous clear so no overflow is ever missed.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Sweep FSM: clr_start is only looked at in RUN, so a pulse during a
    // sweep never restarts it. Read slots stall the sweep counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (slot_clear) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 18'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // RAM port for the next cycle. Address and data hold when the slot is
    // idle; a read only moves the address.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        if (rd_req) begin
            ram_addr_d = rd_addr;
        end else if (slot_clear) begin
            ram_addr_d = clr_cnt_q;
            ram_data_d = 1'b0;
            ram_wren_d = 1'b1;
        end else if (pop) begin
            ram_addr_d = fifo_addr_q[rptr_q];
            ram_data_d = fifo_data_q[rptr_q];
            ram_wren_d = 1'b1;
        end
    end

    // FIFO storage carries no reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            clr_cnt_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_vld_q   <= '0;
            rd_data_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= 1'b0;
            ram_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            // Stage 0: address on the RAM port; stage 1: RAM samples it and
            // ram_q is valid; stage 2: result registered onto rd_data.
            rd_vld_q <= {rd_vld_q[1:0], rd_req};
            if (rd_vld_q[1]) begin
                rd_data_q <= ram_q;
            end
        end
    end

    assign wr_full  = (count_q == FULL_CNT);
    assign ovf      = ovf_q;
    assign clr_busy = (state_q == ST_CLEAR);
    assign rd_valid = rd_vld_q[2];
    assign rd_data  = rd_data_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_wren = ram_wren_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Testbench for fb_arbiter (FB_SIZE=16, FIFO_DEPTH=4).
// A behavioural RAM sits on the RAM port. A cycle-level reference model
// (queues for the write FIFO and pending reads, an array for the logical
// framebuffer contents) predicts every output after each clock edge; the
// scenario tasks add their own directed checks.
module tb_fb_arbiter;
    localparam int FB = 16;
    localparam int D  = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic        wr_data;
    logic        wr_full;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_data;
    logic        rd_valid;
    logic        clr_start;
    logic        clr_busy;
    logic        ovf;
    logic        ovf_clr;
    logic [17:0] ram_addr;
    logic        ram_data;
    logic        ram_wren;
    logic        ram_q;

    int n_cmp = 0;
    int n_err = 0;

    fb_arbiter #(.FB_SIZE(FB), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ovf(ovf), .ovf_clr(ovf_clr),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: read-before-write, one cycle latency.
    bit ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr[7:0]] <= ram_data;
        ram_q <= ram_mem[ram_addr[7:0]];
    end

    // ---------------- reference model / scoreboard ----------------
    bit          m_mem [0:255];
    logic [17:0] mq_addr [$];
    bit          mq_data [$];
    int          rd_due [$];
    bit          rd_val [$];
    bit          m_clearing = 0;
    int          m_clr_idx = 0;
    bit          m_ovf = 0;
    bit          e_wren = 0, e_data = 0, e_valid = 0, e_rdata = 0, e_full = 0;
    logic [17:0] e_addr = '0;
    int          edge_cnt = 0;
    bit          sb_en = 0;

    always @(posedge clk) begin
        bit          was_clr;
        logic [17:0] a;
        bit          d;
        edge_cnt++;
        if (!rst_n) begin
            mq_addr.delete(); mq_data.delete();
            rd_due.delete();  rd_val.delete();
            m_clearing = 0; m_clr_idx = 0; m_ovf = 0;
            e_wren = 0; e_data = 0; e_addr = '0; e_valid = 0; e_rdata = 0;
            sb_en = 1;
        end else begin
            was_clr = m_clearing;
            e_wren  = 0;
            if (rd_req) begin
                e_addr = rd_addr;
                rd_due.push_back(edge_cnt + 2);
                rd_val.push_back(m_mem[rd_addr[7:0]]);
            end else if (m_clearing) begin
                e_addr = 18'(m_clr_idx); e_data = 0; e_wren = 1;
                m_mem[m_clr_idx] = 0;
                m_clr_idx++;
                if (m_clr_idx == FB) m_clearing = 0;
            end else if (mq_addr.size() > 0) begin
                a = mq_addr.pop_front(); d = mq_data.pop_front();
                e_addr = a; e_data = d; e_wren = 1;
                m_mem[a[7:0]] = d;
            end
            if (ovf_clr) m_ovf = 0;
            if (wr_req) begin
                if (mq_addr.size() < D) begin
                    mq_addr.push_back(wr_addr); mq_data.push_back(wr_data);
                end else begin
                    m_ovf = 1;
                end
            end
            if (clr_start && !was_clr) begin
                m_clearing = 1; m_clr_idx = 0;
            end
            e_valid = 0;
            if (rd_due.size() > 0 && rd_due[0] == edge_cnt) begin
                void'(rd_due.pop_front());
                e_rdata = rd_val.pop_front();
                e_valid = 1;
            end
        end
        e_full = (mq_addr.size() == D);
        #1;
        if (sb_en) begin
            n_cmp += 8;
            if (ram_wren !== e_wren) begin n_err++; $display("FAIL sb_ram_wren edge %0d: got %0b exp %0b", edge_cnt, ram_wren, e_wren); end
            if (ram_addr !== e_addr) begin n_err++; $display("FAIL sb_ram_addr edge %0d: got %0d exp %0d", edge_cnt, ram_addr, e_addr); end
            if (ram_data !== e_data) begin n_err++; $display("FAIL sb_ram_data edge %0d: got %0b exp %0b", edge_cnt, ram_data, e_data); end
            if (rd_valid !== e_valid) begin n_err++; $display("FAIL sb_rd_valid edge %0d: got %0b exp %0b", edge_cnt, rd_valid, e_valid); end
            if (rd_data !== e_rdata) begin n_err++; $display("FAIL sb_rd_data edge %0d: got %0b exp %0b", edge_cnt, rd_data, e_rdata); end
            if (wr_full !== e_full) begin n_err++; $display("FAIL sb_wr_full edge %0d: got %0b exp %0b", edge_cnt, wr_full, e_full); end
            if (clr_busy !== m_clearing) begin n_err++; $display("FAIL sb_clr_busy edge %0d: got %0b exp %0b", edge_cnt, clr_busy, m_clearing); end
            if (ovf !== m_ovf) begin n_err++; $display("FAIL sb_ovf edge %0d: got %0b exp %0b", edge_cnt, ovf, m_ovf); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_req = 0; rd_req = 0; clr_start = 0; ovf_clr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; wr_req = 1; wr_addr = 18'd7; wr_data = 1; rd_req = 1; clr_start = 1;
        nxt(); nxt();
        n_cmp += 8;
        if (wr_full !== 1'b0)  begin n_err++; $display("FAIL reset_wr_full: got %0b exp 0", wr_full); end
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b exp 0", rd_valid); end
        if (rd_data !== 1'b0)  begin n_err++; $display("FAIL reset_rd_data: got %0b exp 0", rd_data); end
        if (ovf !== 1'b0)      begin n_err++; $display("FAIL reset_ovf: got %0b exp 0", ovf); end
        if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_clr_busy: got %0b exp 0", clr_busy); end
        if (ram_wren !== 1'b0) begin n_err++; $display("FAIL reset_ram_wren: got %0b exp 0", ram_wren); end
        if (ram_addr !== 18'd0) begin n_err++; $display("FAIL reset_ram_addr: got %0d exp 0", ram_addr); end
        if (ram_data !== 1'b0) begin n_err++; $display("FAIL reset_ram_data: got %0b exp 0", ram_data); end
        idle(); rst_n = 1;
        nxt();
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_write_read();
        wr_req = 1; wr_addr = 18'd5; wr_data = 1;
        nxt();
        idle();
        nxt();
        n_cmp += 3;
        if (ram_wren !== 1'b1) begin n_err++; $display("FAIL wr5_wren: got %0b exp 1", ram_wren); end
        if (ram_addr !== 18'd5) begin n_err++; $display("FAIL wr5_addr: got %0d exp 5", ram_addr); end
        if (ram_data !== 1'b1) begin n_err++; $display("FAIL wr5_data: got %0b exp 1", ram_data); end
        nxt();
        rd_req = 1; rd_addr = 18'd5;
        nxt();
        idle();
        n_cmp += 2;
        if (ram_addr !== 18'd5 || ram_wren !== 1'b0) begin n_err++; $display("FAIL rd5_port: got addr %0d wren %0b exp addr 5 wren 0", ram_addr, ram_wren); end
        nxt();
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd5_early: got rd_valid %0b exp 0", rd_valid); end
        nxt();
        n_cmp += 3;
        if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rd5_valid: got %0b exp 1", rd_valid); end
        if (rd_data !== 1'b1)  begin n_err++; $display("FAIL rd5_data: got %0b exp 1", rd_data); end
        nxt();
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd5_pulse: got rd_valid %0b exp 0", rd_valid); end
        $display("write_read: wrote 1 to addr 5, read back %0b", rd_data);
    endtask

    task automatic test_read_priority();
        logic [17:0] exp_a [4];
        bit          exp_d [4];
        int valid_cnt = 0;
        int wren_reads = 0;
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 18'(100 + i);
            exp_d[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 14; k++) begin
            rd_req  = (k < 10);
            rd_addr = 18'($urandom_range(0, 63));
            wr_req  = (k < 5);
            wr_addr = (k < 4) ? exp_a[k] : 18'd104;
            wr_data = (k < 4) ? exp_d[k] : 1'b1;
            nxt();
            if (rd_valid) valid_cnt++;
            if (k < 10 && ram_wren) wren_reads++;
            if (k == 9) begin
                n_cmp += 2;
                if (wr_full !== 1'b1) begin n_err++; $display("FAIL prio_full: got %0b exp 1", wr_full); end
                if (ovf !== 1'b1)     begin n_err++; $display("FAIL prio_ovf: got %0b exp 1", ovf); end
            end
            if (k >= 10) begin
                n_cmp++;
                if (ram_wren !== 1'b1 || ram_addr !== exp_a[k-10] || ram_data !== exp_d[k-10]) begin
                    n_err++;
                    $display("FAIL prio_drain%0d: got wren %0b addr %0d data %0b exp 1 %0d %0b",
                             k - 10, ram_wren, ram_addr, ram_data, exp_a[k-10], exp_d[k-10]);
                end
            end
        end
        idle();
        n_cmp += 2;
        if (valid_cnt !== 10) begin n_err++; $display("FAIL prio_valid_cnt: got %0d exp 10", valid_cnt); end
        if (wren_reads !== 0) begin n_err++; $display("FAIL prio_wren_in_reads: got %0d exp 0", wren_reads); end
        ovf_clr = 1; nxt(); ovf_clr = 0;
        $display("read_priority: 10 reads, %0d valids, 4 writes drained after", valid_cnt);
    endtask

    task automatic test_full_push_pop();
        logic [17:0] exp_a [4];
        exp_a[0] = 18'd201; exp_a[1] = 18'd202; exp_a[2] = 18'd203; exp_a[3] = 18'd210;
        for (int k = 0; k < 4; k++) begin
            rd_req = 1; rd_addr = 18'($urandom_range(0, 63));
            wr_req = 1; wr_addr = 18'(200 + k); wr_data = 1'(k & 1);
            nxt();
        end
        n_cmp++;
        if (wr_full !== 1'b1) begin n_err++; $display("FAIL pp_fill: got wr_full %0b exp 1", wr_full); end
        rd_req = 0; wr_req = 1; wr_addr = 18'd210; wr_data = 1;
        nxt();
        idle();
        n_cmp += 3;
        if (wr_full !== 1'b1) begin n_err++; $display("FAIL pp_full: got %0b exp 1", wr_full); end
        if (ovf !== 1'b0)     begin n_err++; $display("FAIL pp_ovf: got %0b exp 0", ovf); end
        if (ram_wren !== 1'b1 || ram_addr !== 18'd200) begin n_err++; $display("FAIL pp_pop: got wren %0b addr %0d exp 1 200", ram_wren, ram_addr); end
        for (int k = 0; k < 4; k++) begin
            nxt();
            n_cmp++;
            if (ram_wren !== 1'b1 || ram_addr !== exp_a[k]) begin n_err++; $display("FAIL pp_drain%0d: got wren %0b addr %0d exp 1 %0d", k, ram_wren, ram_addr, exp_a[k]); end
        end
        nxt();
        n_cmp++;
        if (wr_full !== 1'b0 || ram_wren !== 1'b0) begin n_err++; $display("FAIL pp_empty: got full %0b wren %0b exp 0 0", wr_full, ram_wren); end
        $display("full_push_pop: push accepted with pop while full");
    endtask

    task automatic test_clear();
        int busy = 0, writes = 0, bad = 0;
        clr_start = 1;
        nxt();
        clr_start = 0;
        if (clr_busy) busy++;
        for (int k = 1; k <= 24; k++) begin
            clr_start = (k == 5);
            nxt();
            if (clr_busy) busy++;
            if (ram_wren) begin
                if (ram_addr !== 18'(writes) || ram_data !== 1'b0) bad++;
                writes++;
            end
        end
        idle();
        n_cmp += 3;
        if (busy !== 16)   begin n_err++; $display("FAIL clr_busy_cycles: got %0d exp 16", busy); end
        if (writes !== 16) begin n_err++; $display("FAIL clr_writes: got %0d exp 16", writes); end
        if (bad !== 0)     begin n_err++; $display("FAIL clr_order: got %0d bad writes exp 0", bad); end
        $display("clear: %0d busy cycles, %0d zero writes", busy, writes);
        busy = 0; writes = 0;
        clr_start = 1;
        nxt();
        clr_start = 0;
        if (clr_busy) busy++;
        for (int k = 1; k <= 40; k++) begin
            rd_req = (k % 2 == 1); rd_addr = 18'($urandom_range(0, 63));
            nxt();
            if (clr_busy) busy++;
            if (ram_wren) writes++;
        end
        idle();
        nxt(); nxt(); nxt();
        n_cmp += 2;
        if (busy !== 32)   begin n_err++; $display("FAIL clr_rd_busy_cycles: got %0d exp 32", busy); end
        if (writes !== 16) begin n_err++; $display("FAIL clr_rd_writes: got %0d exp 16", writes); end
        $display("clear_with_reads: %0d busy cycles, %0d zero writes", busy, writes);
    endtask

    task automatic test_clear_reset();
        int stray = 0;
        clr_start = 1;
        nxt();
        clr_start = 0;
        for (int k = 1; k <= 7; k++) begin
            wr_req = (k <= 2); wr_addr = 18'(40 + k); wr_data = 1;
            nxt();
        end
        idle();
        n_cmp++;
        if (ram_wren !== 1'b1 || ram_addr !== 18'd6) begin n_err++; $display("FAIL clrrst_pre: got wren %0b addr %0d exp 1 6", ram_wren, ram_addr); end
        rst_n = 0;
        nxt();
        rst_n = 1;
        n_cmp += 3;
        if (clr_busy !== 1'b0) begin n_err++; $display("FAIL clrrst_busy: got %0b exp 0", clr_busy); end
        if (ram_wren !== 1'b0) begin n_err++; $display("FAIL clrrst_wren: got %0b exp 0", ram_wren); end
        if (wr_full !== 1'b0)  begin n_err++; $display("FAIL clrrst_full: got %0b exp 0", wr_full); end
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (ram_wren || clr_busy) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_err++; $display("FAIL clrrst_discard: got %0d stray cycles exp 0", stray); end
        $display("clear_reset: sweep aborted at addr 7, FIFO discarded");
    endtask

    task automatic test_ovf_clr();
        for (int k = 0; k < 4; k++) begin
            rd_req = 1; rd_addr = 18'($urandom_range(0, 63));
            wr_req = 1; wr_addr = 18'(50 + k); wr_data = 1'(k & 1);
            nxt();
        end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovfclr_pre: got %0b exp 0", ovf); end
        wr_req = 1; wr_addr = 18'd60; ovf_clr = 1;
        nxt();
        n_cmp++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovfclr_setwins: got %0b exp 1", ovf); end
        wr_req = 0; ovf_clr = 1;
        nxt();
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovfclr_clear: got %0b exp 0", ovf); end
        idle();
        for (int k = 0; k < 7; k++) nxt();
        $display("ovf_clr: drop beats clear, then cleared");
    endtask

    task automatic test_random();
        int reads = 0, valids = 0;
        for (int k = 0; k < 3000; k++) begin
            rd_req    = ($urandom_range(0, 99) < 40);
            rd_addr   = 18'($urandom_range(0, 63));
            wr_req    = ($urandom_range(0, 99) < 50);
            wr_addr   = 18'($urandom_range(0, 63));
            wr_data   = 1'($urandom_range(0, 1));
            clr_start = ($urandom_range(0, 199) == 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            if (rd_req) reads++;
            nxt();
            if (rd_valid) valids++;
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (rd_valid) valids++;
        end
        n_cmp++;
        if (valids !== reads) begin n_err++; $display("FAIL rand_read_count: got %0d valids exp %0d", valids, reads); end
        $display("random: %0d reads, %0d valids", reads, valids);
    endtask

    initial begin
        rst_n = 0; wr_addr = '0; wr_data = 0; rd_addr = '0; ram_q = 0;
        idle();
        test_reset();
        test_write_read();
        test_read_priority();
        test_full_push_pop();
        test_clear();
        test_clear_reset();
        test_ovf_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
